// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and operand-signedness helpers for the RV32M mul/div unit
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, one bit per cycle, with busy stall and done pulse
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              accept;
   logic              neg_a, neg_b;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   mag_a, mag_b, fast_val, fin_val, quot, remd;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc, div_acc, prod;
   logic [XLEN+1:0]   div_shift, div_trial;
   logic [XLEN:0]     div_rem;

   // Operand conditioning at acceptance: magnitudes plus the special divide cases.
   always_comb begin
      neg_a    = is_signed_a(op) & A[XLEN-1];
      neg_b    = is_signed_b(op) & B[XLEN-1];
      mag_a    = neg_a ? -A : A;
      mag_b    = neg_b ? -B : B;
      div_zero = (B == '0);
      div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                 (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
      fast     = op[2] && (div_zero || div_ovf);
      if (div_zero) begin
         fast_val = op[1] ? A : '1;
      end else begin
         fast_val = op[1] ? '0 : A;
      end
   end

   // One iteration of each algorithm; acc low half holds multiplier or dividend/quotient.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {rem_q, acc_q[XLEN-1]};
      div_trial = div_shift - {2'b00, opb_q};
      div_rem   = div_trial[XLEN+1] ? div_shift[XLEN:0] : div_trial[XLEN:0];
      div_acc   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN+1]};
      prod      = negq_q ? -mul_acc : mul_acc;
      quot      = negq_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
      remd      = negr_q ? -div_rem[XLEN-1:0] : div_rem[XLEN-1:0];
      case (op_q)
         MD_MUL:                       fin_val = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fin_val = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fin_val = quot;
         default:                      fin_val = remd;
      endcase
   end

   assign accept = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_FIN));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      opb_d    = opb_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      case (state_q)
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               acc_d = op_q[2] ? div_acc : mul_acc;
               rem_d = div_rem;
               // Final iteration commits the fixed-up result so it is valid in the done cycle.
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_d  = ST_FIN;
                  result_d = fin_val;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_d   = op;
               negq_d = neg_a ^ neg_b;
               negr_d = neg_a;
               cnt_d  = '0;
               opb_d  = op[2] ? mag_b : mag_a;
               acc_d  = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
               rem_d  = '0;
               if (fast) begin
                  state_d  = ST_FIN;
                  result_d = fast_val;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         opb_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         opb_q    <= opb_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == ST_CALC);
   assign done   = (state_q == ST_FIN);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed bench for muldiv_unit with an arithmetic reference model
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_res = 32'd0;

   muldiv_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return o[2] && ((b == 32'd0) ||
             ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] golden(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (o)
         3'd0: p = {32'd0, a} * {32'd0, b};
         3'd1: p = 64'(sa * sb);
         3'd2: p = 64'(sa * longint'({32'd0, b}));
         3'd3: p = {32'd0, a} * {32'd0, b};
         3'd4: p = (b == 0) ? 64'hFFFF_FFFF : (ovf ? {32'd0, a} : 64'(sa / sb));
         3'd5: p = (b == 0) ? 64'hFFFF_FFFF : {32'd0, a / b};
         3'd6: p = (b == 0) ? {32'd0, a} : (ovf ? 64'd0 : 64'(sa % sb));
         default: p = (b == 0) ? {32'd0, a} : {32'd0, a % b};
      endcase
      return (o == 3'd1 || o == 3'd2 || o == 3'd3) ? p[63:32] : p[31:0];
   endfunction

   // Reference: cycles remaining until the done cycle, and the result it will carry.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_result = 32'd0;
   logic [31:0] m_pend = 32'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left   <= 0;
         m_done   <= 1'b0;
         m_result <= 32'd0;
         m_pend   <= 32'd0;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            if (flush) begin
               m_left <= 0;
            end else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_done   <= 1'b1;
                  m_result <= m_pend;
               end
            end
         end else if (start && !flush) begin
            if (is_fast(op, A, B)) begin
               m_done   <= 1'b1;
               m_result <= golden(op, A, B);
            end else begin
               m_left <= 32;
               m_pend <= golden(op, A, B);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      chk("model done", {31'd0, done}, {31'd0, m_done});
      chk("model result", result, m_result);
   end

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      int bcnt;
      chk({name, " ref"}, golden(o, a, b), exp);
      @(posedge clk); #1;
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
      cyc = 1;
      bcnt = 0;
      while (!done && cyc < 40) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         cyc++;
      end
      chk({name, " latency"}, 32'(cyc), 32'(lat));
      chk({name, " busy cycles"}, 32'(bcnt), 32'(lat - 1));
      chk({name, " result"}, result, exp);
      last_res = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      rst_n = 1'b1;

      run_op("mul 7*-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhu -1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh -1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhsu -1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("div -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem -7%2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("divu",       3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
      run_op("remu",       3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
      run_op("divu by 0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem by 0",   3'd6, 32'd5, 32'd0, 32'd5, 1);
      run_op("div ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("div 100/-7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

      // Flush mid-divide with an ignored start while busy.
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; A = 32'd1000; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy after ignored start", {31'd0, busy}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("busy after flush", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("no done after flush", {31'd0, seen}, 32'd0);
      chk("result kept after flush", result, last_res);

      // Back-to-back: second start issued in the first op's done cycle.
      @(posedge clk); #1;
      start = 1'b1; op = 3'd3; A = 32'h0001_0000; B = 32'h0003_0000;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b first latency", 32'(cyc), 32'd33);
      chk("b2b first result", result, 32'd3);
      start = 1'b1; op = 3'd5; A = 32'd1000; B = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b second latency", 32'(cyc), 32'd33);
      chk("b2b second result", result, 32'd111);
      flush = 1'b1;
      #2;
      chk("done with flush in done cycle", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;

      // Asynchronous reset mid-multiply.
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; A = 32'h0000_1234; B = 32'h0000_5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async reset busy", {31'd0, busy}, 32'd0);
      chk("async reset done", {31'd0, done}, 32'd0);
      chk("async reset result", result, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op("mul 3*4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
